// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the memory-port controller and the memory models.
package mem_ctrl_pkg;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  // Requester IDs used to steer the bank address mux.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  typedef enum logic {
    ST_RUN,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/mem_clear_seq.sv
// Zero-fill sweep sequencer: owns the run/clear state, the sweep address and the done pulse.
module mem_clear_seq #(
  parameter int unsigned DEPTH          = mem_ctrl_pkg::DEPTH,
  parameter int unsigned ADDR_W         = mem_ctrl_pkg::ADDR_W,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr
);
  import mem_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              done_q;

  // start is only honoured in ST_RUN, so a pulse mid-sweep cannot restart the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (start) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == LastAddr) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = (state_q == ST_CLEAR);
  assign done = done_q;
  assign addr = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported bank between fetch and data requesters, with a zero-fill engine.
module mem_port_arbiter #(
  parameter int unsigned DEPTH          = mem_ctrl_pkg::DEPTH,
  parameter int unsigned ADDR_W         = mem_ctrl_pkg::ADDR_W,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  import mem_ctrl_pkg::*;

  localparam int unsigned          StarveW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0]   StarveMax = StarveW'(STARVE_LIMIT);

  logic [StarveW-1:0] starve_q;
  logic [ADDR_W-1:0]  clr_addr;
  logic [ADDR_W-1:0]  req_addr;
  logic               run;
  logic               starve_hit;
  logic               owner;
  logic               if_rvalid_q, d_rvalid_q;
  logic [31:0]        if_rdata_q, d_rdata_q;

  // Only the low ADDR_W address bits reach the bank.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

  mem_clear_seq #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk   (clk),
    .reset (reset),
    .start (clr_start),
    .busy  (clr_busy),
    .done  (clr_done),
    .addr  (clr_addr)
  );

  // Nothing touches the bank while reset is asserted, so an aborted sweep leaves the rest intact.
  assign run        = ~reset & ~clr_busy;
  assign starve_hit = (starve_q == StarveMax);
  assign if_gnt     = run & if_req & (~d_req | starve_hit);
  assign d_gnt      = run & d_req & ~if_gnt;
  assign owner      = if_gnt ? REQ_IF : REQ_D;
  assign req_addr   = (owner == REQ_IF) ? if_addr[ADDR_W-1:0] : d_addr[ADDR_W-1:0];

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (clr_busy && !reset) begin
      mem_write = 1'b1;
      mem_addr  = {{(32 - ADDR_W){1'b0}}, clr_addr};
    end else if (if_gnt || d_gnt) begin
      mem_addr = {{(32 - ADDR_W){1'b0}}, req_addr};
      if (d_gnt && d_we) begin
        mem_write = 1'b1;
        mem_wdata = d_wdata;
      end else begin
        mem_read = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!if_req || if_gnt) begin
      starve_q <= '0;
    end else if (!starve_hit) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= if_gnt;
      d_rvalid_q  <= d_gnt & ~d_we;
      if (if_gnt) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_gnt && !d_we) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Controller that shares one single-ported 1024 x 32 memory bank (combinational read, write on rising clock edge) between the instruction-fetch requester and the data (load/store) requester of the processor. It grants at most one access per cycle, with data priority and a fetch-starvation guard. It returns registered read data one cycle after the grant. It also contains a clear engine that zero-fills the whole bank on request.

## Interface
- DEPTH, 1024: number of memory words.
- ADDR_W, 10: word-index bits forwarded to the bank; equals log2(DEPTH).
- STARVE_LIMIT, 4: consecutive denied fetch cycles after which fetch wins.
- CLEAR_ON_RESET, 0: 1 means the clear sweep starts automatically after reset.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held until granted.
- if_addr  in  32  fetch address; only bits [ADDR_W-1:0] are used.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid (registered).
- if_rdata  out  32  fetch read data (registered).
- d_req  in  1  data request; held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address; only bits [ADDR_W-1:0] are used.
- d_wdata  in  32  store data.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  load data valid (registered).
- d_rdata  out  32  load data (registered).
- clr_start  in  1  one-cycle pulse that starts the zero-fill.
- clr_busy  out  1  high while the sweep runs.
- clr_done  out  1  one-cycle pulse when the sweep completes.
- mem_read  out  1  read enable to the bank.
- mem_write  out  1  write enable to the bank.
- mem_addr  out  32  bank address; bits [31:ADDR_W] are always 0.
- mem_wdata  out  32  bank write data.
- mem_rdata  in  32  combinational read data from the bank.

## Operation
- States:
  - ST_RUN: normal arbitration.
  - ST_CLEAR: zero-fill sweep.
- Reset enters ST_RUN, or ST_CLEAR when CLEAR_ON_RESET=1.
- Arbitration in ST_RUN:
  - Data wins by default.
  - Fetch wins when starve_cnt == STARVE_LIMIT.
  - A lone requester is always granted.
  - Exactly one of if_gnt/d_gnt is high, or neither.
- starve_cnt:
  - Increments when if_req=1 and if_gnt=0.
  - Clears on if_gnt or when if_req=0.
  - Saturates at STARVE_LIMIT.
- Bank drive:
  - Granted load or fetch: mem_read=1, mem_addr=address.
  - Granted store: mem_write=1, mem_addr=d_addr, mem_wdata=d_wdata.
  - No grant: all mem_* outputs are 0.
- ST_RUN to ST_CLEAR: clr_start=1 in ST_RUN. Grants in that same cycle are still honoured; the next cycle is the first ST_CLEAR cycle.
- ST_CLEAR behaviour:
  - if_gnt and d_gnt are 0.
  - clr_busy is 1.
  - Cycle k writes 0 to address k (mem_write=1) for k = 0..DEPTH-1.
- Sweep completion:
  - After address DEPTH-1, the block returns to ST_RUN.
  - clr_done=1 during the first ST_RUN cycle only.
- clr_start while in ST_CLEAR is ignored.
- Reset mid-sweep aborts it: address counter to 0, no clr_done.

## Timing
- Grant is combinational in the request cycle.
- A store is committed at the rising edge ending its grant cycle.
- Read latency:
  - if_rvalid is 1 in the cycle after if_gnt.
  - d_rvalid is 1 in the cycle after (d_gnt & ~d_we).
- The matching rdata register captures mem_rdata at that edge.
- rdata holds its value until the next valid.
- Reset values: if_rvalid, d_rvalid, clr_busy, clr_done, if_rdata, d_rdata are all 0; starve_cnt and the sweep counter are 0.
- A full sweep takes exactly DEPTH cycles of clr_busy=1.
- The address counter is ADDR_W bits wide and does not wrap into a second pass.

## Structure
- Shared package mem_ctrl_pkg holds:
  - the state enum (ST_RUN, ST_CLEAR);
  - the DEPTH and ADDR_W constants, also used by the memory modules;
  - the requester ID constants REQ_IF and REQ_D.
- One sub-module, mem_clear_seq, holds the sweep counter, clr_busy and clr_done.
- The top level keeps arbitration, starve_cnt and the response registers.

## Test plan
- Fetch only, if_addr=5, bank word 5 = 32'h1234 -> if_gnt in the same cycle; next cycle if_rvalid=1, if_rdata=32'h1234.
- Store then load: d_we=1, d_addr=3, d_wdata=32'hDEAD, then d_we=0, d_addr=3 -> d_rvalid one cycle after the load grant, d_rdata=32'hDEAD.
- Both requesting continuously -> data granted 4 cycles, fetch granted on the 5th, pattern repeats.
- clr_start pulse -> clr_busy=1 for exactly 1024 cycles, every address 0..1023 written with 0, clr_done pulses once; requests stalled then served.
- reset asserted at sweep address 500 -> clr_busy=0 next cycle, no clr_done, words 500..1023 unchanged.
- clr_start during a sweep -> ignored, sweep length stays 1024 cycles.
